// File: rtl/interrupt_request_arbiter.sv
// CPU interrupt front end: synchronises NMI/IRQ/soft-reset sources, latches pending
// requests and presents one prioritised request (RST > NMI > IRQ) with its vector.
//
// state   | meaning
// R_IDLE  | soft_reset_n high, nothing counting
// R_COUNT | soft_reset_n low, counting consecutive low cycles toward RST_HOLD
// R_HELD  | reset qualified, waiting for button release (reset_active = 1)
module interrupt_request_arbiter #(
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ppu_status,
  input  logic [7:0]  ppu_ctrl1,
  input  logic        nIRQ,
  input  logic        soft_reset_n,
  input  logic        irq_mask,
  input  logic        halt,
  input  logic        ack,
  output logic        req_valid,
  output logic [1:0]  req_kind,
  output logic [15:0] req_vector,
  output logic        reset_active
);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_COUNT = 2'd1,
    R_HELD  = 2'd2
  } rst_state_t;

  localparam logic [1:0]  KIND_NONE = 2'd0;
  localparam logic [1:0]  KIND_RST  = 2'd1;
  localparam logic [1:0]  KIND_NMI  = 2'd2;
  localparam logic [1:0]  KIND_IRQ  = 2'd3;
  localparam logic [15:0] VEC_NONE  = 16'h0000;
  localparam logic [15:0] VEC_RST   = 16'hFFFC;
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;
  localparam logic [7:0]  HOLD_TC   = 8'(RST_HOLD);

  logic [SYNC_STAGES-1:0] irq_sync;
  logic [SYNC_STAGES-1:0] srst_sync;
  logic                   irq_line_n;
  logic                   srst_low;
  logic                   nmi_line;
  logic                   nmi_prev;
  logic                   nmi_edge;
  logic                   nmi_pend;
  logic                   rst_pend;
  logic                   irq_req;
  logic                   take_ack;
  logic                   clr_rst;
  logic                   clr_nmi;
  rst_state_t             rst_state;
  logic [7:0]             hold_cnt;
  logic [7:0]             hold_inc;
  logic                   unused_ppu_bits;

  assign unused_ppu_bits = ^{ppu_status[6:0], ppu_ctrl1[6:0]};

  // Synchronisers reset to 1 so an idle (high) line never looks asserted out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_sync  <= '1;
      srst_sync <= '1;
    end else begin
      irq_sync  <= {irq_sync[SYNC_STAGES-2:0], nIRQ};
      srst_sync <= {srst_sync[SYNC_STAGES-2:0], soft_reset_n};
    end
  end

  assign irq_line_n = irq_sync[SYNC_STAGES-1];
  assign srst_low   = !srst_sync[SYNC_STAGES-1];
  assign irq_req    = !irq_line_n && !irq_mask;

  assign nmi_line = ppu_status[7] & ppu_ctrl1[7];
  assign nmi_edge = nmi_line && !nmi_prev;

  assign take_ack = !halt && req_valid && ack;
  assign clr_rst  = take_ack && (req_kind == KIND_RST);
  assign clr_nmi  = take_ack && (req_kind == KIND_NMI);

  // A fresh edge in the same cycle as an NMI ack keeps the request pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_line;
      if (clr_nmi)  nmi_pend <= 1'b0;
      if (nmi_edge) nmi_pend <= 1'b1;
    end
  end

  assign hold_inc = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_state    <= R_IDLE;
      hold_cnt     <= 8'd0;
      rst_pend     <= 1'b0;
      reset_active <= 1'b0;
    end else begin
      if (clr_rst) rst_pend <= 1'b0;
      case (rst_state)
        R_IDLE: begin
          if (srst_low) begin
            hold_cnt <= 8'd1;
            if (HOLD_TC == 8'd1) begin
              rst_pend     <= 1'b1;
              reset_active <= 1'b1;
              rst_state    <= R_HELD;
            end else begin
              rst_state <= R_COUNT;
            end
          end
        end
        R_COUNT: begin
          if (!srst_low) begin
            hold_cnt  <= 8'd0;
            rst_state <= R_IDLE;
          end else begin
            hold_cnt <= hold_inc;
            if (hold_inc == HOLD_TC) begin
              rst_pend     <= 1'b1;
              reset_active <= 1'b1;
              rst_state    <= R_HELD;
            end
          end
        end
        R_HELD: begin
          if (!srst_low) begin
            hold_cnt     <= 8'd0;
            reset_active <= 1'b0;
            rst_state    <= R_IDLE;
          end
        end
        default: begin
          hold_cnt     <= 8'd0;
          reset_active <= 1'b0;
          rst_state    <= R_IDLE;
        end
      endcase
    end
  end

  // Once presented, a request is frozen until acked; no pre-emption by higher sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid  <= 1'b0;
      req_kind   <= KIND_NONE;
      req_vector <= VEC_NONE;
    end else if (!halt) begin
      if (req_valid) begin
        if (ack) begin
          req_valid  <= 1'b0;
          req_kind   <= KIND_NONE;
          req_vector <= VEC_NONE;
        end
      end else if (rst_pend) begin
        req_valid  <= 1'b1;
        req_kind   <= KIND_RST;
        req_vector <= VEC_RST;
      end else if (nmi_pend) begin
        req_valid  <= 1'b1;
        req_kind   <= KIND_NMI;
        req_vector <= VEC_NMI;
      end else if (irq_req) begin
        req_valid  <= 1'b1;
        req_kind   <= KIND_IRQ;
        req_vector <= VEC_IRQ;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_request_arbiter.sv
// Directed bench for interrupt_request_arbiter: NMI edge, IRQ masking, soft-reset
// qualification, priority, halt freeze and asynchronous reset.
module tb_interrupt_request_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ppu_status;
  logic [7:0]  ppu_ctrl1;
  logic        nIRQ;
  logic        soft_reset_n;
  logic        irq_mask;
  logic        halt;
  logic        ack;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [15:0] req_vector;
  logic        reset_active;

  int checks = 0;
  int errors = 0;

  localparam logic [18:0] REQ_NONE = {1'b0, 2'd0, 16'h0000};
  localparam logic [18:0] REQ_RST  = {1'b1, 2'd1, 16'hFFFC};
  localparam logic [18:0] REQ_NMI  = {1'b1, 2'd2, 16'hFFFA};
  localparam logic [18:0] REQ_IRQ  = {1'b1, 2'd3, 16'hFFFE};

  logic [18:0] obs;
  assign obs = {req_valid, req_kind, req_vector};

  interrupt_request_arbiter #(.RST_HOLD(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ppu_status(ppu_status), .ppu_ctrl1(ppu_ctrl1),
    .nIRQ(nIRQ), .soft_reset_n(soft_reset_n), .irq_mask(irq_mask), .halt(halt),
    .ack(ack), .req_valid(req_valid), .req_kind(req_kind), .req_vector(req_vector),
    .reset_active(reset_active)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    checks++; if (obs !== REQ_NONE || reset_active !== 1'b0) begin errors++; $display("FAIL reset_held: got %h/%b want %h/0", obs, reset_active, REQ_NONE); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick(3);
    checks++; if (obs !== REQ_NONE || reset_active !== 1'b0) begin errors++; $display("FAIL reset_release: got %h/%b want %h/0", obs, reset_active, REQ_NONE); end
  endtask

  task automatic test_nmi_edge;
    ppu_status = 8'h80;
    tick(1);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL nmi_latency: got %h want %h", obs, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_NMI) begin errors++; $display("FAIL nmi_present: got %h want %h", obs, REQ_NMI); end
    tick(3);
    checks++; if (obs !== REQ_NMI) begin errors++; $display("FAIL nmi_hold: got %h want %h", obs, REQ_NMI); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL nmi_ack: got %h want %h", obs, REQ_NONE); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL nmi_level_no_retrigger: got %h want %h at %0d", obs, REQ_NONE, i); end
    end
    ppu_status = 8'h00;
    tick(2);
  endtask

  task automatic test_irq_mask;
    irq_mask = 1'b1;
    nIRQ = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL irq_masked: got %h want %h at %0d", obs, REQ_NONE, i); end
    end
    irq_mask = 1'b0;
    tick(1);
    checks++; if (obs !== REQ_IRQ) begin errors++; $display("FAIL irq_present: got %h want %h", obs, REQ_IRQ); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL irq_ack_gap: got %h want %h", obs, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_IRQ) begin errors++; $display("FAIL irq_represent: got %h want %h", obs, REQ_IRQ); end
    nIRQ = 1'b1;
    tick(3);
    checks++; if (obs !== REQ_IRQ) begin errors++; $display("FAIL irq_withdraw_held: got %h want %h", obs, REQ_IRQ); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL irq_final_ack: got %h want %h", obs, REQ_NONE); end
    tick(3);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL irq_gone: got %h want %h", obs, REQ_NONE); end
  endtask

  task automatic test_rst_hold;
    soft_reset_n = 1'b0;
    tick(3);
    soft_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (obs !== REQ_NONE || reset_active !== 1'b0) begin errors++; $display("FAIL rst_glitch: got %h/%b want %h/0 at %0d", obs, reset_active, REQ_NONE, i); end
    end
    soft_reset_n = 1'b0;
    tick(5);
    checks++; if (obs !== REQ_NONE || reset_active !== 1'b0) begin errors++; $display("FAIL rst_counting: got %h/%b want %h/0", obs, reset_active, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_NONE || reset_active !== 1'b1) begin errors++; $display("FAIL rst_qualified: got %h/%b want %h/1", obs, reset_active, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_RST || reset_active !== 1'b1) begin errors++; $display("FAIL rst_present: got %h/%b want %h/1", obs, reset_active, REQ_RST); end
    tick(3);
    soft_reset_n = 1'b1;
    tick(2);
    checks++; if (reset_active !== 1'b1) begin errors++; $display("FAIL rst_release_sync: got %b want 1", reset_active); end
    tick(1);
    checks++; if (obs !== REQ_RST || reset_active !== 1'b0) begin errors++; $display("FAIL rst_released: got %h/%b want %h/0", obs, reset_active, REQ_RST); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL rst_ack: got %h want %h", obs, REQ_NONE); end
    tick(2);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL rst_no_repeat: got %h want %h", obs, REQ_NONE); end
  endtask

  task automatic test_priority;
    halt = 1'b1;
    nIRQ = 1'b0;
    irq_mask = 1'b0;
    soft_reset_n = 1'b0;
    tick(5);
    ppu_status = 8'h80;
    tick(1);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL prio_halted: got %h want %h", obs, REQ_NONE); end
    tick(2);
    halt = 1'b0;
    tick(1);
    checks++; if (obs !== REQ_RST || reset_active !== 1'b1) begin errors++; $display("FAIL prio_rst: got %h/%b want %h/1", obs, reset_active, REQ_RST); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL prio_gap1: got %h want %h", obs, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_NMI) begin errors++; $display("FAIL prio_nmi: got %h want %h", obs, REQ_NMI); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL prio_gap2: got %h want %h", obs, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_IRQ) begin errors++; $display("FAIL prio_irq: got %h want %h", obs, REQ_IRQ); end
    soft_reset_n = 1'b1;
    ppu_status = 8'h00;
    tick(1);
    ppu_status = 8'h80;
    tick(3);
    checks++; if (obs !== REQ_IRQ) begin errors++; $display("FAIL no_preempt: got %h want %h", obs, REQ_IRQ); end
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL prio_gap3: got %h want %h", obs, REQ_NONE); end
    tick(1);
    checks++; if (obs !== REQ_NMI || reset_active !== 1'b0) begin errors++; $display("FAIL preempt_after_ack: got %h/%b want %h/0", obs, reset_active, REQ_NMI); end
    nIRQ = 1'b1;
    tick(3);
    ack = 1'b1; tick(1); ack = 1'b0;
    tick(2);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL prio_drained: got %h want %h", obs, REQ_NONE); end
    ppu_status = 8'h00;
    tick(2);
  endtask

  task automatic test_halt;
    halt = 1'b1;
    ppu_status = 8'h80;
    tick(5);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL halt_blocks: got %h want %h", obs, REQ_NONE); end
    halt = 1'b0;
    tick(1);
    checks++; if (obs !== REQ_NMI) begin errors++; $display("FAIL halt_release: got %h want %h", obs, REQ_NMI); end
    halt = 1'b1;
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NMI) begin errors++; $display("FAIL halt_ack_ignored: got %h want %h", obs, REQ_NMI); end
    tick(2);
    halt = 1'b0;
    ack = 1'b1; tick(1); ack = 1'b0;
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL halt_ack_taken: got %h want %h", obs, REQ_NONE); end
    tick(3);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL halt_done: got %h want %h", obs, REQ_NONE); end
    ppu_status = 8'h00;
    tick(2);
  endtask

  task automatic test_async_reset;
    ppu_status = 8'h80;
    tick(2);
    checks++; if (obs !== REQ_NMI) begin errors++; $display("FAIL areset_pre: got %h want %h", obs, REQ_NMI); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (obs !== REQ_NONE || reset_active !== 1'b0) begin errors++; $display("FAIL areset_now: got %h/%b want %h/0", obs, reset_active, REQ_NONE); end
    ppu_status = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(5);
    checks++; if (obs !== REQ_NONE) begin errors++; $display("FAIL areset_no_stale: got %h want %h", obs, REQ_NONE); end
  endtask

  initial begin
    rst = 1'b0;
    ppu_status = 8'h00;
    ppu_ctrl1 = 8'h80;
    nIRQ = 1'b1;
    soft_reset_n = 1'b1;
    irq_mask = 1'b0;
    halt = 1'b0;
    ack = 1'b0;
    #12;
    test_reset;
    test_nmi_edge;
    test_irq_mask;
    test_rst_hold;
    test_priority;
    test_halt;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
